// File: rtl/alu_pipe.sv
// Pipelined ALU with valid/ready handshake: N-bit operands, STAGES-cycle latency.
// Optional feature macro: ALU_FLAGS_EN (when undefined, flags are tied to zero).
module alu_pipe #(
  parameter int N      = 8,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [3:0]   instruction,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] ALU_out,
  output logic [3:0]   flags
);

  localparam logic [N-1:0] ONE = N'(1);

  logic         advance;
  logic [N-1:0] mul_lo;
  logic [N-1:0] res_c;

  logic [STAGES-1:0] vld_q;
  logic [N-1:0]      res_q [STAGES];

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_q[STAGES-1];
  assign ALU_out   = res_q[STAGES-1];

`ifdef ALU_FLAGS_EN
  logic [N-1:0] prod_hi;
  assign {prod_hi, mul_lo} = {{N{1'b0}}, A} * {{N{1'b0}}, B};
`else
  assign mul_lo = A * B;
`endif

  always_comb begin
    res_c = '0;
    case (instruction)
      4'b0000: res_c = A + B;
      4'b0001: res_c = A - B;
      4'b0010: res_c = A + ONE;
      4'b0011: res_c = A - ONE;
      4'b0100: res_c = '0 - A;
      4'b0101: res_c = A;
      4'b0110: res_c = mul_lo;
      4'b0111: res_c = A;
      4'b1000: res_c = A & B;
      4'b1001: res_c = A | B;
      4'b1010: res_c = A ^ B;
      4'b1011: res_c = ~A;
      4'b1100: res_c = ~(A & B);
      4'b1101: res_c = ~(A | B);
      4'b1110: res_c = {A[N-2:0], 1'b0};
      4'b1111: res_c = {1'b0, A[N-1:1]};
    endcase
  end

  // All stages move together or hold together; there is no bubble collapse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < STAGES; i++) res_q[i] <= '0;
    end else if (advance) begin
      vld_q[0] <= in_valid;
      res_q[0] <= res_c;
      for (int i = 1; i < STAGES; i++) begin
        vld_q[i] <= vld_q[i-1];
        res_q[i] <= res_q[i-1];
      end
    end
  end

`ifdef ALU_FLAGS_EN
  logic [N-1:0] ax, ay, fres;
  logic [N:0]   ar;
  logic         sub, is_arith, fv, fc;
  logic [3:0]   flg_c;
  logic [3:0]   flg_q [STAGES];

  // Arithmetic ops share one (N+1)-bit adder/subtractor so carry/borrow is bit N.
  always_comb begin
    ax       = A;
    ay       = B;
    sub      = 1'b0;
    is_arith = 1'b0;
    case (instruction)
      4'b0000: is_arith = 1'b1;
      4'b0001: begin is_arith = 1'b1; sub = 1'b1; end
      4'b0010: begin is_arith = 1'b1; ay = ONE; end
      4'b0011: begin is_arith = 1'b1; ay = ONE; sub = 1'b1; end
      4'b0100: begin is_arith = 1'b1; ax = '0; ay = A; sub = 1'b1; end
      4'b0111: begin is_arith = 1'b1; sub = 1'b1; end
      default: ;
    endcase
    ar = sub ? ({1'b0, ax} - {1'b0, ay}) : ({1'b0, ax} + {1'b0, ay});
    fv   = 1'b0;
    fc   = 1'b0;
    fres = (instruction == 4'b0111) ? ar[N-1:0] : res_c;
    if (is_arith) begin
      fc = ar[N];
      fv = sub ? ((ax[N-1] != ay[N-1]) && (ar[N-1] != ax[N-1]))
               : ((ax[N-1] == ay[N-1]) && (ar[N-1] != ax[N-1]));
    end
    case (instruction)
      4'b0110: fc = |prod_hi;
      4'b1110: fc = A[N-1];
      4'b1111: fc = A[0];
      default: ;
    endcase
    flg_c = {fv, fc, fres[N-1], (fres == '0)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) flg_q[i] <= '0;
    end else if (advance) begin
      flg_q[0] <= flg_c;
      for (int i = 1; i < STAGES; i++) flg_q[i] <= flg_q[i-1];
    end
  end

  assign flags = flg_q[STAGES-1];
`else
  assign flags = 4'b0000;
`endif

endmodule
